// File: rtl/rs_station_param_pkg.sv
// Shared types for the reservation station: opcode encodings, default entry
// layout and the occupancy-width helper.
package rs_pkg;

  localparam int RS_DEPTH  = 4;
  localparam int RS_DATA_W = 16;
  localparam int RS_TAG_W  = 3;
  localparam int RS_FUNC_W = 4;

  typedef enum logic [RS_FUNC_W-1:0] {
    FUNC_ADD = 4'b0000,
    FUNC_SUB = 4'b0001,
    FUNC_MUL = 4'b0010,
    FUNC_DIV = 4'b0011,
    FUNC_LD  = 4'b0100,
    FUNC_ST  = 4'b0101,
    FUNC_BEQ = 4'b0110,
    FUNC_BNE = 4'b0111
  } rs_func_e;

  typedef struct packed {
    logic [RS_FUNC_W-1:0] func;
    logic [RS_TAG_W-1:0]  rob;
    logic                 s1_rdy;
    logic [RS_DATA_W-1:0] s1_val;
    logic [RS_TAG_W-1:0]  s1_tag;
    logic                 s2_rdy;
    logic [RS_DATA_W-1:0] s2_val;
    logic [RS_TAG_W-1:0]  s2_tag;
  } rs_entry_t;

  function automatic int occ_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/rs_station_param_if.sv
// Dispatch, CDB and issue signals of one reservation station.
// Handshakes: a transfer happens on a rising edge where valid && ready; valid
// never waits on ready, and the issue side may change its offer while !ready.
interface rs_station_param_if #(
  parameter int DATA_W = 16,
  parameter int TAG_W  = 3,
  parameter int FUNC_W = 4
);
  logic              disp_valid;
  logic              disp_ready;
  logic [FUNC_W-1:0] disp_func;
  logic [TAG_W-1:0]  disp_rob;
  logic              disp_s1_rdy;
  logic [DATA_W-1:0] disp_s1_val;
  logic [TAG_W-1:0]  disp_s1_tag;
  logic              disp_s2_rdy;
  logic [DATA_W-1:0] disp_s2_val;
  logic [TAG_W-1:0]  disp_s2_tag;
  logic              cdb_valid;
  logic [TAG_W-1:0]  cdb_tag;
  logic [DATA_W-1:0] cdb_data;
  logic              iss_valid;
  logic              iss_ready;
  logic [FUNC_W-1:0] iss_func;
  logic [TAG_W-1:0]  iss_rob;
  logic [DATA_W-1:0] iss_a;
  logic [DATA_W-1:0] iss_b;

  modport slave (
    input  disp_valid, disp_func, disp_rob,
    input  disp_s1_rdy, disp_s1_val, disp_s1_tag,
    input  disp_s2_rdy, disp_s2_val, disp_s2_tag,
    input  cdb_valid, cdb_tag, cdb_data, iss_ready,
    output disp_ready, iss_valid, iss_func, iss_rob, iss_a, iss_b
  );

  modport master (
    output disp_valid, disp_func, disp_rob,
    output disp_s1_rdy, disp_s1_val, disp_s1_tag,
    output disp_s2_rdy, disp_s2_val, disp_s2_tag,
    output cdb_valid, cdb_tag, cdb_data, iss_ready,
    input  disp_ready, iss_valid, iss_func, iss_rob, iss_a, iss_b
  );
endinterface

// File: rtl/rs_station_param_oldest_ready_sel.sv
// Priority picker: lowest set bit of the request vector, as one-hot and index.
module rs_oldest_ready_sel #(
  parameter  int N  = 4,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  i_req,
  output logic [N-1:0]  o_onehot,
  output logic [IW-1:0] o_idx,
  output logic          o_valid
);

  // Scan from the top so the lowest requesting slot is the last one written.
  always_comb begin
    o_onehot = '0;
    o_idx    = '0;
    o_valid  = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (i_req[i]) begin
        o_onehot    = '0;
        o_onehot[i] = 1'b1;
        o_idx       = IW'(i);
        o_valid     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rs_station_param.sv
// Reservation station as a compacting age queue: slot 0 is oldest, CDB snoop
// wakes operands, the oldest fully-ready entry is offered to the unit.
module rs_station_param
  import rs_pkg::*;
#(
  parameter int DEPTH  = RS_DEPTH,
  parameter int DATA_W = RS_DATA_W,
  parameter int TAG_W  = RS_TAG_W,
  parameter int FUNC_W = RS_FUNC_W
) (
  input  logic                       clk1,
  input  logic                       rst_n,
  input  logic                       flush,
  rs_station_param_if.slave          bus,
  output logic [$clog2(DEPTH+1)-1:0] occupancy
);

  localparam int OW = occ_w(DEPTH);
  localparam int IW = $clog2(DEPTH);

  typedef struct packed {
    logic [FUNC_W-1:0] func;
    logic [TAG_W-1:0]  rob;
    logic              s1_rdy;
    logic [DATA_W-1:0] s1_val;
    logic [TAG_W-1:0]  s1_tag;
    logic              s2_rdy;
    logic [DATA_W-1:0] s2_val;
    logic [TAG_W-1:0]  s2_tag;
  } entry_t;

  entry_t [DEPTH-1:0] r_ent;
  entry_t [DEPTH-1:0] w_above;
  entry_t [DEPTH-1:0] w_nxt;
  entry_t             w_disp;
  logic [OW-1:0]      r_occ, w_occ_base, w_occ_nxt;
  logic [DEPTH-1:0]   w_rdy_vec, w_sel_oh;
  logic [IW-1:0]      w_sel_idx;
  logic               w_sel_valid, w_iss_fire, w_disp_fire;
  logic [FUNC_W-1:0]  w_sel_func, r_last_func;
  logic [TAG_W-1:0]   w_sel_rob, r_last_rob;
  logic [DATA_W-1:0]  w_sel_a, w_sel_b, r_last_a, r_last_b;

  function automatic entry_t wake(input entry_t e, input logic cv,
                                  input logic [TAG_W-1:0] ct, input logic [DATA_W-1:0] cd);
    entry_t r;
    r = e;
    if (!e.s1_rdy && cv && (e.s1_tag == ct)) begin
      r.s1_rdy = 1'b1;
      r.s1_val = cd;
    end
    if (!e.s2_rdy && cv && (e.s2_tag == ct)) begin
      r.s2_rdy = 1'b1;
      r.s2_val = cd;
    end
    return r;
  endfunction

  // Readiness comes from stored state only, so a CDB wakeup issues next cycle.
  always_comb begin
    w_rdy_vec = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_rdy_vec[i] = (OW'(i) < r_occ) && r_ent[i].s1_rdy && r_ent[i].s2_rdy;
    end
  end

  rs_oldest_ready_sel #(.N(DEPTH)) u_sel (
    .i_req    (w_rdy_vec),
    .o_onehot (w_sel_oh),
    .o_idx    (w_sel_idx),
    .o_valid  (w_sel_valid)
  );

  always_comb begin
    w_sel_func = '0;
    w_sel_rob  = '0;
    w_sel_a    = '0;
    w_sel_b    = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (w_sel_oh[i]) begin
        w_sel_func = w_sel_func | r_ent[i].func;
        w_sel_rob  = w_sel_rob  | r_ent[i].rob;
        w_sel_a    = w_sel_a    | r_ent[i].s1_val;
        w_sel_b    = w_sel_b    | r_ent[i].s2_val;
      end
    end
  end

  assign bus.iss_valid  = w_sel_valid;
  assign bus.iss_func   = w_sel_valid ? w_sel_func : r_last_func;
  assign bus.iss_rob    = w_sel_valid ? w_sel_rob  : r_last_rob;
  assign bus.iss_a      = w_sel_valid ? w_sel_a    : r_last_a;
  assign bus.iss_b      = w_sel_valid ? w_sel_b    : r_last_b;
  assign bus.disp_ready = (r_occ < OW'(DEPTH)) || (w_sel_valid && bus.iss_ready);
  assign occupancy      = r_occ;

  assign w_iss_fire  = w_sel_valid && bus.iss_ready && !flush;
  assign w_disp_fire = bus.disp_valid && bus.disp_ready && !flush;
  assign w_occ_base  = r_occ - OW'(w_iss_fire);
  assign w_occ_nxt   = w_occ_base + OW'(w_disp_fire);
  assign w_above     = r_ent >> $bits(entry_t);

  always_comb begin
    w_disp        = '0;
    w_disp.func   = bus.disp_func;
    w_disp.rob    = bus.disp_rob;
    w_disp.s1_rdy = bus.disp_s1_rdy;
    w_disp.s1_val = bus.disp_s1_val;
    w_disp.s1_tag = bus.disp_s1_tag;
    w_disp.s2_rdy = bus.disp_s2_rdy;
    w_disp.s2_val = bus.disp_s2_val;
    w_disp.s2_tag = bus.disp_s2_tag;
    w_disp        = wake(w_disp, bus.cdb_valid, bus.cdb_tag, bus.cdb_data);
  end

  // Slots at or above the issued one take their upper neighbour; the new op
  // lands just past the surviving entries.
  always_comb begin
    w_nxt = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_nxt[i] = wake((w_iss_fire && (IW'(i) >= w_sel_idx)) ? w_above[i] : r_ent[i],
                      bus.cdb_valid, bus.cdb_tag, bus.cdb_data);
      if (w_disp_fire && (w_occ_base == OW'(i))) begin
        w_nxt[i] = w_disp;
      end
    end
  end

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      r_ent       <= '0;
      r_occ       <= '0;
      r_last_func <= '0;
      r_last_rob  <= '0;
      r_last_a    <= '0;
      r_last_b    <= '0;
    end else begin
      if (w_sel_valid) begin
        r_last_func <= w_sel_func;
        r_last_rob  <= w_sel_rob;
        r_last_a    <= w_sel_a;
        r_last_b    <= w_sel_b;
      end
      if (flush) begin
        r_ent <= '0;
        r_occ <= '0;
      end else begin
        r_ent <= w_nxt;
        r_occ <= w_occ_nxt;
      end
    end
  end

endmodule

// File: tb/tb_rs_station_param.sv
// Bench for rs_station_param: queue-based reference model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_rs_station_param;
  import rs_pkg::*;

  localparam int DEPTH = 4;

  logic       clk1;
  logic       rst_n;
  logic       flush;
  logic [2:0] occupancy;

  rs_station_param_if bus ();

  rs_station_param #(.DEPTH(DEPTH)) dut (
    .clk1      (clk1),
    .rst_n     (rst_n),
    .flush     (flush),
    .bus       (bus),
    .occupancy (occupancy)
  );

  typedef struct {
    logic [3:0]  func;
    logic [2:0]  rob;
    logic        r1;
    logic [15:0] v1;
    logic [2:0]  t1;
    logic        r2;
    logic [15:0] v2;
    logic [2:0]  t2;
  } m_ent_t;

  m_ent_t mq[$];
  m_ent_t m_last;
  int     n_cmp  = 0;
  int     n_fail = 0;

  // ---------------- clock ----------------
  initial begin
    clk1 = 1'b0;
    forever #5 clk1 = ~clk1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic m_ent_t m_wake(input m_ent_t e);
    m_ent_t r;
    r = e;
    if (bus.cdb_valid && !r.r1 && r.t1 == bus.cdb_tag) begin r.r1 = 1'b1; r.v1 = bus.cdb_data; end
    if (bus.cdb_valid && !r.r2 && r.t2 == bus.cdb_tag) begin r.r2 = 1'b1; r.v2 = bus.cdb_data; end
    return r;
  endfunction

  // ---------------- reference model + per-cycle compare ----------------
  always @(negedge clk1) begin
    int     sel;
    logic   ev;
    logic   edr;
    m_ent_t shown;
    m_ent_t ne;
    if (!rst_n) begin
      mq.delete();
      m_last = '{default: '0};
      chk("rst_iss_valid", 32'(bus.iss_valid), 32'd0);
      chk("rst_occupancy", 32'(occupancy), 32'd0);
      chk("rst_disp_ready", 32'(bus.disp_ready), 32'd1);
      chk("rst_iss_data", {bus.iss_a, bus.iss_b}, 32'd0);
      chk("rst_iss_tag", {25'd0, bus.iss_func, bus.iss_rob}, 32'd0);
    end else begin
      sel = -1;
      for (int i = 0; i < mq.size(); i++)
        if (sel < 0 && mq[i].r1 && mq[i].r2) sel = i;
      ev    = (sel >= 0);
      shown = ev ? mq[sel] : m_last;
      edr   = (mq.size() < DEPTH) || (ev && bus.iss_ready);
      chk("iss_valid", 32'(bus.iss_valid), 32'(ev));
      chk("iss_func", 32'(bus.iss_func), 32'(shown.func));
      chk("iss_rob", 32'(bus.iss_rob), 32'(shown.rob));
      chk("iss_a", 32'(bus.iss_a), 32'(shown.v1));
      chk("iss_b", 32'(bus.iss_b), 32'(shown.v2));
      chk("disp_ready", 32'(bus.disp_ready), 32'(edr));
      chk("occupancy", 32'(occupancy), 32'(mq.size()));
      m_last = shown;
      if (flush) begin
        mq.delete();
      end else begin
        if (ev && bus.iss_ready) mq.delete(sel);
        for (int i = 0; i < mq.size(); i++) mq[i] = m_wake(mq[i]);
        if (bus.disp_valid && edr) begin
          ne = '{bus.disp_func, bus.disp_rob, bus.disp_s1_rdy, bus.disp_s1_val, bus.disp_s1_tag,
                 bus.disp_s2_rdy, bus.disp_s2_val, bus.disp_s2_tag};
          mq.push_back(m_wake(ne));
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle();
    bus.disp_valid = 1'b0;
    bus.cdb_valid  = 1'b0;
    flush          = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk1);
    #1;
    idle();
    #1;
  endtask

  task automatic disp(input logic [3:0] f, input logic [2:0] rob,
                      input logic r1, input logic [15:0] v1, input logic [2:0] t1,
                      input logic r2, input logic [15:0] v2, input logic [2:0] t2);
    bus.disp_valid  = 1'b1;
    bus.disp_func   = f;
    bus.disp_rob    = rob;
    bus.disp_s1_rdy = r1;
    bus.disp_s1_val = v1;
    bus.disp_s1_tag = t1;
    bus.disp_s2_rdy = r2;
    bus.disp_s2_val = v2;
    bus.disp_s2_tag = t2;
  endtask

  task automatic cdb(input logic [2:0] t, input logic [15:0] d);
    bus.cdb_valid = 1'b1;
    bus.cdb_tag   = t;
    bus.cdb_data  = d;
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    rst_n = 1'b0;
    idle();
    bus.iss_ready = 1'b0;
    disp(FUNC_ADD, 3'd0, 1'b0, 16'd0, 3'd0, 1'b0, 16'd0, 3'd0);
    bus.disp_valid = 1'b0;
    cdb(3'd0, 16'd0);
    bus.cdb_valid = 1'b0;
    repeat (3) @(posedge clk1);
    #1 rst_n = 1'b1;
    #1;
    chk("lit_post_reset_occ", 32'(occupancy), 32'd0);

    // Reset in the middle of a live entry
    disp(FUNC_MUL, 3'd1, 1'b1, 16'd3, 3'd0, 1'b1, 16'd4, 3'd0);
    tick();
    chk("lit_pre_rst_valid", 32'(bus.iss_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("lit_mid_rst_occ", 32'(occupancy), 32'd0);
    chk("lit_mid_rst_iss_a", 32'(bus.iss_a), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // Basic: ADD rob=2, 5 + 7
    disp(FUNC_ADD, 3'd2, 1'b1, 16'd5, 3'd0, 1'b1, 16'd7, 3'd0);
    tick();
    chk("lit_basic_valid", 32'(bus.iss_valid), 32'd1);
    chk("lit_basic_a", 32'(bus.iss_a), 32'd5);
    chk("lit_basic_b", 32'(bus.iss_b), 32'd7);
    chk("lit_basic_rob", 32'(bus.iss_rob), 32'd2);
    chk("lit_basic_occ", 32'(occupancy), 32'd1);
    bus.iss_ready = 1'b1;
    tick();
    bus.iss_ready = 1'b0;
    chk("lit_basic_occ0", 32'(occupancy), 32'd0);
    chk("lit_basic_hold_a", 32'(bus.iss_a), 32'd5);

    // Wakeup: s1 waits on tag 3; tag 4 broadcast must not wake it
    disp(FUNC_SUB, 3'd1, 1'b0, 16'd0, 3'd3, 1'b1, 16'h0011, 3'd0);
    tick();
    cdb(3'd4, 16'h0055);
    tick();
    chk("lit_wake_wrong_tag", 32'(bus.iss_valid), 32'd0);
    cdb(3'd3, 16'h00AA);
    #1;
    chk("lit_wake_same_cycle", 32'(bus.iss_valid), 32'd0);
    tick();
    chk("lit_wake_valid", 32'(bus.iss_valid), 32'd1);
    chk("lit_wake_a", 32'(bus.iss_a), 32'h00AA);
    bus.iss_ready = 1'b1;
    tick();
    bus.iss_ready = 1'b0;

    // Same-cycle bypass on operand 2
    disp(FUNC_ADD, 3'd5, 1'b1, 16'd3, 3'd0, 1'b0, 16'd0, 3'd6);
    cdb(3'd6, 16'd9);
    tick();
    chk("lit_bypass_valid", 32'(bus.iss_valid), 32'd1);
    chk("lit_bypass_b", 32'(bus.iss_b), 32'd9);
    bus.iss_ready = 1'b1;
    tick();
    bus.iss_ready = 1'b0;

    // Fill with four waiting entries
    disp(FUNC_LD,  3'd0, 1'b0, 16'd0, 3'd4, 1'b1, 16'h0010, 3'd0); tick();
    disp(FUNC_ST,  3'd1, 1'b0, 16'd0, 3'd5, 1'b1, 16'h0011, 3'd0); tick();
    disp(FUNC_BEQ, 3'd2, 1'b0, 16'd0, 3'd6, 1'b1, 16'h0012, 3'd0); tick();
    disp(FUNC_BNE, 3'd3, 1'b0, 16'd0, 3'd7, 1'b1, 16'h0013, 3'd0); tick();
    chk("lit_full_occ", 32'(occupancy), 32'd4);
    chk("lit_full_ready", 32'(bus.disp_ready), 32'd0);
    disp(FUNC_DIV, 3'd4, 1'b1, 16'h0014, 3'd0, 1'b0, 16'd0, 3'd1);
    tick();
    chk("lit_full_reject_occ", 32'(occupancy), 32'd4);
    cdb(3'd6, 16'h0066);
    tick();
    chk("lit_full_slot2_rob", 32'(bus.iss_rob), 32'd2);
    bus.iss_ready = 1'b1;
    disp(FUNC_DIV, 3'd4, 1'b1, 16'h0014, 3'd0, 1'b0, 16'd0, 3'd1);
    #1;
    chk("lit_full_issue_ready", 32'(bus.disp_ready), 32'd1);
    tick();
    bus.iss_ready = 1'b0;
    chk("lit_full_keep_occ", 32'(occupancy), 32'd4);
    cdb(3'd1, 16'h0021);
    tick();
    chk("lit_order_rob4", 32'(bus.iss_rob), 32'd4);
    chk("lit_order_b", 32'(bus.iss_b), 32'h0021);
    cdb(3'd5, 16'h0025);
    tick();
    chk("lit_older_wins", 32'(bus.iss_rob), 32'd1);
    bus.iss_ready = 1'b1;
    tick();
    chk("lit_then_rob4", 32'(bus.iss_rob), 32'd4);
    tick();
    bus.iss_ready = 1'b0;
    chk("lit_left_two", 32'(occupancy), 32'd2);

    // Age order: slots 1 and 3 share tag 7
    disp(FUNC_ADD, 3'd5, 1'b0, 16'd0, 3'd2, 1'b1, 16'h0015, 3'd0); tick();
    disp(FUNC_SUB, 3'd6, 1'b0, 16'd0, 3'd7, 1'b1, 16'h0016, 3'd0); tick();
    cdb(3'd7, 16'h0077);
    tick();
    chk("lit_age_first", 32'(bus.iss_rob), 32'd3);
    chk("lit_age_first_a", 32'(bus.iss_a), 32'h0077);
    bus.iss_ready = 1'b1;
    tick();
    chk("lit_age_second", 32'(bus.iss_rob), 32'd6);
    tick();
    bus.iss_ready = 1'b0;
    chk("lit_age_done", 32'(bus.iss_valid), 32'd0);

    // Flush beats dispatch and issue
    disp(FUNC_ADD, 3'd7, 1'b1, 16'h0001, 3'd0, 1'b1, 16'h0002, 3'd0);
    tick();
    chk("lit_flush_pre_occ", 32'(occupancy), 32'd3);
    flush = 1'b1;
    bus.iss_ready = 1'b1;
    disp(FUNC_ADD, 3'd1, 1'b1, 16'h0003, 3'd0, 1'b1, 16'h0004, 3'd0);
    tick();
    bus.iss_ready = 1'b0;
    chk("lit_flush_occ", 32'(occupancy), 32'd0);
    chk("lit_flush_valid", 32'(bus.iss_valid), 32'd0);
    tick();
    chk("lit_flush_dropped", 32'(occupancy), 32'd0);
    repeat (2) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/rs_station_param.md
Name: rs_station_param

Overview:
- Parametrised reservation station for the Tomasulo core. One instance per functional-unit class (add/branch/load-store, mul/div).
- Accepts dispatched ops with operand values or ROB tags, and snoops the common data bus (CDB) to resolve pending operands.
- Issues the oldest fully-ready entry to its functional unit over a valid/ready handshake.
- Adds what the single-array version lacks: reset, capacity/full back-pressure, CDB wakeup, same-cycle bypass, age-ordered issue, flush.

Parameters:
DEPTH, 4, number of RS entries (>=2)
DATA_W, 16, operand value width
TAG_W, 3, ROB index width
FUNC_W, 4, opcode width

Ports:
clk1  in  1  sole clock, rising edge
rst_n  in  1  asynchronous active-low reset
flush  in  1  synchronous clear of all entries (mispredict)
disp_valid  in  1  dispatch request
disp_ready  out  1  RS can accept this cycle
disp_func  in  FUNC_W  opcode
disp_rob  in  TAG_W  destination ROB index
disp_s1_rdy  in  1  1 = disp_s1_val holds the value; 0 = wait on disp_s1_tag
disp_s1_val  in  DATA_W  operand 1 value
disp_s1_tag  in  TAG_W  operand 1 producer ROB tag
disp_s2_rdy, disp_s2_val, disp_s2_tag  in  1/DATA_W/TAG_W  same for operand 2
cdb_valid  in  1  CDB broadcast valid
cdb_tag  in  TAG_W  broadcasting ROB tag
cdb_data  in  DATA_W  broadcast value
iss_valid  out  1  an entry is issuing
iss_ready  in  1  functional unit accepts
iss_func  out  FUNC_W  issued opcode
iss_rob  out  TAG_W  issued ROB index
iss_a  out  DATA_W  operand 1
iss_b  out  DATA_W  operand 2
occupancy  out  $clog2(DEPTH+1)  valid entry count

Behaviour:
- Storage is a compacting age queue. Slot 0 is oldest; valid slots are contiguous 0..occupancy-1.
- Entry fields: func, rob, s1_rdy, s1_val, s1_tag, s2_rdy, s2_val, s2_tag.
- Reset (async, rst_n=0): all entries invalid, occupancy=0, iss_valid=0, all iss_* data outputs 0, disp_ready=1. Reset mid-operation discards all entries with no issue.
- flush=1: next edge all entries invalid, occupancy=0. Dispatch and issue in that cycle are ignored; flush has priority. iss_valid is still combinationally visible that cycle but must not be counted as issued.
- disp_ready = (occupancy < DEPTH) || (iss_valid && iss_ready). Full with a simultaneous issue still accepts.
- Dispatch fire = disp_valid && disp_ready. The new entry is written at slot occupancy, or occupancy-1 if an issue fires the same cycle.
- CDB wakeup, per valid entry and operand: if !sN_rdy && cdb_valid && sN_tag==cdb_tag, then at the edge sN_val<=cdb_data and sN_rdy<=1. All matching entries wake in the same cycle.
- Dispatch bypass: if a dispatched operand has rdy=0 and its tag matches a valid CDB in the same cycle, it is stored as ready with cdb_data. No entry may miss a broadcast.
- Issue select (combinational): the lowest-index valid slot with s1_rdy && s2_rdy.
  - iss_valid=1 when such a slot exists; iss_* show its fields.
  - An entry woken by the CDB becomes issuable in the next cycle, not the same cycle.
  - No ready entry: iss_valid=0 and iss_* hold their last value.
- Issue fire = iss_valid && iss_ready. The selected slot is removed; slots above it shift down one at the edge. CDB wakeups apply to the shifted entries in the same edge.
- iss_valid/iss_* must stay stable while iss_ready=0, unless an older entry becomes ready. Oldest-ready always wins; this is not a sticky grant.
- occupancy next = occupancy + dispatch fire − issue fire. It never exceeds DEPTH and never underflows.
- Opcode is not interpreted; routing of func classes to instances is done outside this block.
- Latency: dispatch with both operands ready to iss_valid is 1 cycle.

Decomposition:
- Package rs_pkg holds:
  - func encodings: ADD=0000, SUB=0001, MUL=0010, DIV=0011, LD=0100, ST=0101, BEQ=0110, BNE=0111.
  - a packed rs_entry_t struct parametrised via localparams.
  - an occupancy-width function.
- Sub-module rs_oldest_ready_sel: a DEPTH-wide priority picker taking a ready vector and returning one-hot plus index. It is reused by the ROB commit logic.

Test Plan:
- Reset/basic: rst_n low mid-run, then dispatch ADD rob=2, s1=5, s2=7 both ready → next cycle iss_valid=1, iss_a=5, iss_b=7, iss_rob=2; occupancy 1→0 after iss_ready.
- Wakeup: dispatch SUB with s1 waiting on tag 3; CDB tag=3 data=0x00AA → iss_valid rises the cycle after the CDB, iss_a=0x00AA. CDB tag=4 leaves it pending.
- Same-cycle bypass: dispatch with s2 tag=6 while cdb_valid tag=6 data=9 → entry stored ready; issues next cycle with iss_b=9.
- Full/back-pressure (DEPTH=4): fill 4 non-ready entries → disp_ready=0, occupancy=4. Then wake slot 2 with iss_ready=1 plus a simultaneous dispatch → accepted, occupancy stays 4, order preserved.
- Age order: slots 1 and 3 woken by one CDB → slot 1 issues first, slot 3 (now slot 2) issues next cycle.
- Flush: occupancy=3 with flush=1 and disp_valid=1 → occupancy=0, iss_valid=0 next cycle, dispatched op dropped.
